// File: rtl/lsu_ctrl_if.sv
// Core request/response and data-memory signals of the load/store controller.
// No latency of its own; plain wires between the core, the controller and memory.
// req_ready gates the request side; the response side has no backpressure.
interface lsu_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             req_valid;
  logic             req_ready;
  logic             req_we;
  logic [2:0]       req_funct3;
  logic [WIDTH-1:0] req_addr;
  logic [WIDTH-1:0] req_wdata;
  logic             rsp_valid;
  logic [WIDTH-1:0] rsp_rdata;
  logic             rsp_err;
  logic [WIDTH-1:0] mem_addr;
  logic             mem_we;
  logic [WIDTH-1:0] mem_wdata;
  logic [WIDTH-1:0] mem_rdata;

  // Core plus memory side: drives requests and memory read data.
  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_addr, mem_we, mem_wdata
  );

  // Controller side.
  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/lsu_ctrl.sv
// Byte/half/word load-store controller onto a word-organised memory (RMW for sub-word stores).
// Latency accept->rsp_valid: error 1, load 2, SW 2, SB/SH 3 cycles; one request in flight.
// req_ready only in IDLE; rsp_valid is a one-cycle pulse with no backpressure.
module lsu_ctrl #(
  parameter int WIDTH = 32
) (
  input logic        clk,
  input logic        reset,
  lsu_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  state_t             state;
  state_t             state_nxt;

  logic               we_q;
  logic [2:0]         f3_q;
  logic [1:0]         off_q;
  logic [WIDTH-1:0]   wdata_q;
  logic [WIDTH-1:0]   word_q;
  logic [WIDTH-1:2]   mem_addr_q;
  logic               rsp_valid_q;
  logic               rsp_err_q;
  logic [WIDTH-1:0]   rsp_rdata_q;

  logic               accept;
  logic               legal;
  logic               misal;
  logic               req_bad;
  logic [WIDTH-1:0]   merged;

  // Pick the addressed lane of a memory word and extend it per funct3.
  function automatic logic [WIDTH-1:0] extract(input logic [WIDTH-1:0] w,
                                               input logic [2:0] f3,
                                               input logic [1:0] off);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{off, 3'b000} +: 8];
    h = off[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  extract = {{24{b[7]}}, b};
      3'b001:  extract = {{16{h[15]}}, h};
      3'b100:  extract = {24'h0, b};
      3'b101:  extract = {16'h0, h};
      default: extract = w;
    endcase
  endfunction

  assign accept        = bus.req_valid && (state == IDLE);
  assign bus.req_ready = (state == IDLE);
  assign bus.mem_addr  = {mem_addr_q, 2'b00};
  assign bus.mem_we    = (state == WR) && !reset;
  assign bus.mem_wdata = (state == WR) ? merged : '0;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;

  // Classify the incoming request: funct3 legality for its direction and alignment.
  always_comb begin
    legal = 1'b0;
    misal = 1'b0;
    case (bus.req_funct3)
      3'b000: legal = 1'b1;
      3'b001: begin
        legal = 1'b1;
        misal = bus.req_addr[0];
      end
      3'b010: begin
        legal = 1'b1;
        misal = (bus.req_addr[1:0] != 2'b00);
      end
      3'b100, 3'b101: begin
        legal = !bus.req_we;
        misal = bus.req_funct3[0] && bus.req_addr[0];
      end
      default: legal = 1'b0;
    endcase
    req_bad = !legal || misal;
  end

  // Store word: full wdata for SW, otherwise the captured word with one lane replaced.
  always_comb begin
    merged = wdata_q;
    if (f3_q[1:0] == 2'b00) begin
      merged = word_q;
      merged[{off_q, 3'b000} +: 8] = wdata_q[7:0];
    end else if (f3_q[1:0] == 2'b01) begin
      merged = word_q;
      merged[{off_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state: bad requests go straight to RESP, SW skips the read, RMW stores read first.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (req_bad)                                     state_nxt = RESP;
          else if (bus.req_we && bus.req_funct3 == 3'b010) state_nxt = WR;
          else                                             state_nxt = RD;
        end
      end
      RD:      state_nxt = we_q ? WR : RESP;
      WR:      state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request latch, captured word, memory address and registered response.
  always_ff @(posedge clk) begin
    if (reset) begin
      we_q        <= 1'b0;
      f3_q        <= '0;
      off_q       <= '0;
      wdata_q     <= '0;
      word_q      <= '0;
      mem_addr_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      case (state)
        IDLE: begin
          if (accept) begin
            we_q    <= bus.req_we;
            f3_q    <= bus.req_funct3;
            off_q   <= bus.req_addr[1:0];
            wdata_q <= bus.req_wdata;
            if (req_bad) begin
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
            end else begin
              // Only legal accesses move the memory address; errors touch nothing.
              mem_addr_q <= bus.req_addr[WIDTH-1:2];
            end
          end
        end
        RD: begin
          word_q <= bus.mem_rdata;
          if (!we_q) begin
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= extract(bus.mem_rdata, f3_q, off_q);
          end
        end
        WR:      rsp_valid_q <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl with a small word memory model.
// Checks responses, latencies and memory write pulses against hand-computed values.
// Requests are driven on the falling edge and outputs sampled on the falling edge.
module tb_lsu_ctrl;

  logic clk = 1'b0;
  logic reset;
  logic mem_init;

  always #5 clk = ~clk;

  lsu_ctrl_if #(.WIDTH(32)) bus ();

  lsu_ctrl #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [31:0] mem [0:127];

  assign bus.mem_rdata = mem[bus.mem_addr[8:2]];

  // Word memory: combinational read, synchronous write, preload while mem_init.
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 128; i++) mem[i] <= 32'h0;
      mem[64] <= 32'h8899AABB;
    end else if (bus.mem_we) begin
      mem[bus.mem_addr[8:2]] <= bus.mem_wdata;
    end
  end

  int          n_asserts = 0;
  int          n_fail    = 0;
  int          got_lat;
  int          got_rsp;
  int          got_we;
  int          got_we_cyc;
  logic [31:0] got_rdata;
  logic [31:0] got_wdata;
  logic        got_err;
  int          acc_cnt;
  int          rsp_cnt;
  int          bad_rd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request and watch 6 cycles after the accept edge.
  task automatic run_req(input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd);
    @(negedge clk);
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wd;
    bus.req_valid  = 1'b1;
    got_lat    = 0;
    got_rsp    = 0;
    got_we     = 0;
    got_we_cyc = 0;
    got_rdata  = 32'hX;
    got_wdata  = 32'hX;
    got_err    = 1'bX;
    @(negedge clk);
    bus.req_valid = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      if (bus.mem_we) begin
        got_we++;
        got_we_cyc = c;
        got_wdata  = bus.mem_wdata;
      end
      if (bus.rsp_valid) begin
        got_rsp++;
        if (got_lat == 0) begin
          got_lat   = c;
          got_rdata = bus.rsp_rdata;
          got_err   = bus.rsp_err;
        end
      end
      if (c < 6) @(negedge clk);
    end
  endtask

  initial begin
    reset          = 1'b1;
    mem_init       = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'h0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_ready",     {31'h0, bus.req_ready}, 32'h1);
    chk("rst_rsp_valid", {31'h0, bus.rsp_valid}, 32'h0);
    chk("rst_rsp_err",   {31'h0, bus.rsp_err},   32'h0);
    chk("rst_rsp_rdata", bus.rsp_rdata,          32'h0);
    chk("rst_mem_we",    {31'h0, bus.mem_we},    32'h0);
    chk("rst_mem_addr",  bus.mem_addr,           32'h0);
    chk("rst_mem_wdata", bus.mem_wdata,          32'h0);
    reset    = 1'b0;
    mem_init = 1'b0;

    // Byte loads
    run_req(1'b0, 3'b000, 32'h101, 32'h0);
    chk("lb_rdata", got_rdata, 32'hFFFFFFAA);
    chk("lb_lat",   got_lat,   2);
    chk("lb_err",   {31'h0, got_err}, 32'h0);
    chk("lb_nrsp",  got_rsp,   1);
    run_req(1'b0, 3'b100, 32'h101, 32'h0);
    chk("lbu_rdata", got_rdata, 32'h000000AA);
    chk("lbu_lat",   got_lat,   2);
    chk("lbu_err",   {31'h0, got_err}, 32'h0);

    // Half and word loads
    run_req(1'b0, 3'b001, 32'h102, 32'h0);
    chk("lh_rdata", got_rdata, 32'hFFFF8899);
    chk("lh_we",    got_we,    0);
    run_req(1'b0, 3'b101, 32'h102, 32'h0);
    chk("lhu_rdata", got_rdata, 32'h00008899);
    chk("lhu_we",    got_we,    0);
    run_req(1'b0, 3'b010, 32'h100, 32'h0);
    chk("lw_rdata", got_rdata, 32'h8899AABB);
    chk("lw_lat",   got_lat,   2);
    chk("lw_we",    got_we,    0);

    // Byte store read-modify-write
    run_req(1'b1, 3'b000, 32'h102, 32'h12345678);
    chk("sb_we_cnt", got_we,     1);
    chk("sb_we_cyc", got_we_cyc, 2);
    chk("sb_wdata",  got_wdata,  32'h8878AABB);
    chk("sb_lat",    got_lat,    3);
    chk("sb_rdata",  got_rdata,  32'h0);
    chk("sb_err",    {31'h0, got_err}, 32'h0);
    run_req(1'b0, 3'b010, 32'h100, 32'h0);
    chk("sb_readback", got_rdata, 32'h8878AABB);

    // Half store
    run_req(1'b1, 3'b001, 32'h100, 32'h0000CAFE);
    chk("sh_we_cnt", got_we,    1);
    chk("sh_wdata",  got_wdata, 32'h8878CAFE);
    chk("sh_lat",    got_lat,   3);
    run_req(1'b0, 3'b010, 32'h100, 32'h0);
    chk("sh_readback", got_rdata, 32'h8878CAFE);

    // Word store: no read cycle
    run_req(1'b1, 3'b010, 32'h104, 32'hDEADBEEF);
    chk("sw_we_cnt", got_we,     1);
    chk("sw_we_cyc", got_we_cyc, 1);
    chk("sw_wdata",  got_wdata,  32'hDEADBEEF);
    chk("sw_lat",    got_lat,    2);
    run_req(1'b0, 3'b010, 32'h104, 32'h0);
    chk("sw_readback", got_rdata, 32'hDEADBEEF);

    // Errors: misaligned word load, misaligned half store, illegal load, illegal store
    run_req(1'b0, 3'b010, 32'h103, 32'h0);
    chk("elw_err",   {31'h0, got_err}, 32'h1);
    chk("elw_rdata", got_rdata, 32'h0);
    chk("elw_lat",   got_lat,   1);
    chk("elw_we",    got_we,    0);
    run_req(1'b1, 3'b001, 32'h101, 32'h11111111);
    chk("esh_err", {31'h0, got_err}, 32'h1);
    chk("esh_lat", got_lat, 1);
    chk("esh_we",  got_we,  0);
    run_req(1'b0, 3'b011, 32'h100, 32'h0);
    chk("ef3_err",   {31'h0, got_err}, 32'h1);
    chk("ef3_rdata", got_rdata, 32'h0);
    chk("ef3_lat",   got_lat,   1);
    run_req(1'b1, 3'b100, 32'h100, 32'h22222222);
    chk("est_err", {31'h0, got_err}, 32'h1);
    chk("est_we",  got_we, 0);
    run_req(1'b0, 3'b010, 32'h100, 32'h0);
    chk("err_mem_unchanged", got_rdata, 32'h8878CAFE);

    // Reset during the WR cycle of SB 0x100
    @(negedge clk);
    bus.req_we     = 1'b1;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = 32'h100;
    bus.req_wdata  = 32'h00000055;
    bus.req_valid  = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("rwr_rd_we", {31'h0, bus.mem_we}, 32'h0);
    @(negedge clk);
    chk("rwr_wr_we", {31'h0, bus.mem_we}, 32'h1);
    reset = 1'b1;
    #1;
    chk("rwr_we_suppressed", {31'h0, bus.mem_we}, 32'h0);
    @(negedge clk);
    chk("rwr_ready", {31'h0, bus.req_ready}, 32'h1);
    chk("rwr_rsp",   {31'h0, bus.rsp_valid}, 32'h0);
    reset   = 1'b0;
    rsp_cnt = 0;
    for (int c = 0; c < 4; c++) begin
      if (bus.rsp_valid) rsp_cnt++;
      @(negedge clk);
    end
    chk("rwr_no_rsp", rsp_cnt, 0);
    run_req(1'b0, 3'b010, 32'h100, 32'h0);
    chk("rwr_mem_unchanged", got_rdata, 32'h8878CAFE);

    // Back-to-back LW 0x100 with req_valid held; garbage on req_* while busy
    acc_cnt = 0;
    rsp_cnt = 0;
    bad_rd  = 0;
    @(negedge clk);
    for (int k = 0; k < 12; k++) begin
      if (bus.rsp_valid) begin
        rsp_cnt++;
        if (bus.rsp_rdata !== 32'h8878CAFE || bus.rsp_err !== 1'b0) bad_rd++;
      end
      bus.req_valid = 1'b1;
      if (bus.req_ready) begin
        acc_cnt++;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'b010;
        bus.req_addr   = 32'h100;
      end else begin
        bus.req_we     = 1'b1;
        bus.req_funct3 = 3'b011;
        bus.req_addr   = 32'h107;
      end
      @(negedge clk);
    end
    bus.req_valid = 1'b0;
    chk("b2b_accepts",   acc_cnt, 4);
    chk("b2b_responses", rsp_cnt, 4);
    chk("b2b_bad_rdata", bad_rd,  0);
    repeat (3) @(negedge clk);
    run_req(1'b0, 3'b010, 32'h104, 32'h0);
    chk("b2b_no_stray_write", got_rdata, 32'hDEADBEEF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
